// File: rtl/periph_bus_ic_if.sv
// rtl/periph_bus_ic_if.sv - core/peripheral bus bundle for periph_bus_ic
interface periph_bus_ic_if #(
    parameter int N_SLAVES = 8
);
    logic                   req_i;
    logic                   we_i;
    logic [3:0]             be_i;
    logic [31:0]            addr_i;
    logic [31:0]            wdata_i;
    logic [31:0]            rdata_o;
    logic                   stall_o;
    logic                   err_o;
    logic [N_SLAVES-1:0]    s_req_o;
    logic                   s_we_o;
    logic [3:0]             s_be_o;
    logic [31:0]            s_addr_o;
    logic [31:0]            s_wdata_o;
    logic [32*N_SLAVES-1:0] s_rdata_i;
    logic [N_SLAVES-1:0]    s_ready_i;

    // Interconnect view: slave of the core, master of the peripherals.
    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, s_rdata_i, s_ready_i,
        output rdata_o, stall_o, err_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
    );

    // Core plus peripheral view, the side that drives the interconnect.
    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, s_rdata_i, s_ready_i,
        input  rdata_o, stall_o, err_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
    );
endinterface

// File: rtl/periph_bus_ic.sv
// rtl/periph_bus_ic.sv - address-decoded core-to-peripheral interconnect with registered read data
// Define BUS_TIMEOUT_EN to abort BUSY with a bus error after TIMEOUT_CYCLES cycles without ready.
module periph_bus_ic #(
    parameter int N_SLAVES       = 8,
    parameter int SEL_MSB        = 31,
    parameter int SEL_LSB        = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic            clk_i,
    input logic            rst_i,
    periph_bus_ic_if.slave bus
);
    localparam int          SEL_W    = SEL_MSB - SEL_LSB + 1;
    localparam logic [31:0] SEL_MASK = ((32'd1 << SEL_W) - 32'd1) << SEL_LSB;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic                we_q;
    logic [3:0]          be_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic [N_SLAVES-1:0] s_req_q;

    logic [SEL_W-1:0]    req_sel;
    logic                req_mapped;
    logic [N_SLAVES-1:0] req_onehot;
    logic [31:0]         act_rdata;
    logic                act_ready;
    logic                to_hit;

    assign req_sel    = bus.addr_i[SEL_MSB:SEL_LSB];
    assign req_mapped = 32'(req_sel) < 32'(N_SLAVES);

    // s_req_q is one-hot only in BUSY, so it doubles as the active-slave mux select.
    always_comb begin
        req_onehot = '0;
        act_rdata  = '0;
        act_ready  = 1'b0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (32'(req_sel) == 32'(k)) begin
                req_onehot[k] = 1'b1;
            end
            if (s_req_q[k]) begin
                act_rdata = bus.s_rdata_i[32*k +: 32];
                act_ready = bus.s_ready_i[k];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state == BUSY) && (32'(to_cnt) == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (state != BUSY) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign to_hit         = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            s_req_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        be_q    <= bus.be_i;
                        addr_q  <= bus.addr_i & ~SEL_MASK;
                        wdata_q <= bus.wdata_i;
                        if (req_mapped) begin
                            s_req_q <= req_onehot;
                            state   <= BUSY;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                BUSY: begin
                    // Ready wins over a timeout expiring in the same cycle.
                    if (act_ready) begin
                        rdata_q <= we_q ? 32'd0 : act_rdata;
                        s_req_q <= '0;
                        state   <= DONE;
                    end else if (to_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        s_req_q <= '0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stall_o   = bus.req_i & (state != DONE) & ~rst_i;
    assign bus.rdata_o   = rdata_q;
    assign bus.err_o     = err_q;
    assign bus.s_req_o   = s_req_q;
    assign bus.s_we_o    = we_q;
    assign bus.s_be_o    = be_q;
    assign bus.s_addr_o  = addr_q;
    assign bus.s_wdata_o = wdata_q;
endmodule

// File: tb/tb_periph_bus_ic.sv
// tb/tb_periph_bus_ic.sv - randomized self-checking bench for periph_bus_ic against a transaction-level model
module tb_periph_bus_ic;
    localparam int NS = 8;
`ifdef BUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    logic [31:0]   sdata [NS];
    logic [NS-1:0] sready;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    periph_bus_ic_if #(.N_SLAVES(NS)) bus ();

    periph_bus_ic #(
        .N_SLAVES(NS),
        .SEL_MSB(31),
        .SEL_LSB(24),
        .TIMEOUT_CYCLES(TO == 0 ? 255 : TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always_comb begin
        bus.s_rdata_i = '0;
        for (int k = 0; k < NS; k++) bus.s_rdata_i[32*k +: 32] = sdata[k];
    end
    assign bus.s_ready_i = sready;

    typedef struct {
        int            stall_n;
        int            sreq_n;
        logic [NS-1:0] sreq_or;
        bit            sreq_bad;
        logic [31:0]   s_addr;
        logic [31:0]   s_wdata;
        logic          s_we;
        logic [3:0]    s_be;
        logic [31:0]   rdata;
        logic [31:0]   rdata_first;
        logic          err;
        bit            err_early;
        bit            done;
        int            done_cyc;
    } obs_t;

    typedef struct {
        int            stall_n;
        int            sreq_n;
        logic [NS-1:0] sreq_or;
        logic [31:0]   s_addr;
        logic [31:0]   rdata;
        logic          err;
    } exp_t;

    // Transaction-level expectation: selector from the top address byte, ready after b BUSY cycles.
    function automatic exp_t model(input logic we, input logic [31:0] addr, input int b);
        exp_t e;
        int   sel;
        sel      = int'(addr / 32'h0100_0000);
        e.s_addr = addr % 32'h0100_0000;
        if (sel >= NS) begin
            e.stall_n = 1; e.sreq_n = 0; e.sreq_or = '0; e.rdata = '0; e.err = 1'b1;
        end else if (TO != 0 && b > TO) begin
            e.stall_n = 1 + TO; e.sreq_n = TO; e.sreq_or = NS'(1) << sel; e.rdata = '0; e.err = 1'b1;
        end else begin
            e.stall_n = 1 + b; e.sreq_n = b; e.sreq_or = NS'(1) << sel;
            e.rdata = we ? 32'd0 : sdata[sel]; e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int b, input bit noise, output obs_t o);
        o.stall_n = 0; o.sreq_n = 0; o.sreq_or = '0; o.sreq_bad = 0;
        o.s_addr = '0; o.s_wdata = '0; o.s_we = 1'b0; o.s_be = '0;
        o.rdata = '0; o.rdata_first = '0; o.err = 1'b0; o.err_early = 0; o.done = 0; o.done_cyc = 0;
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.wdata_i = wdata; bus.be_i = be;
        for (int c = 0; c < 300 && !o.done; c++) begin
            #1;
            if (c == 0) o.rdata_first = bus.rdata_o;
            if (bus.stall_o === 1'b0) begin
                o.done = 1; o.rdata = bus.rdata_o; o.err = bus.err_o; o.done_cyc = cyc;
                if (bus.s_req_o !== '0) o.sreq_bad = 1;
            end else begin
                o.stall_n++;
                if (bus.err_o !== 1'b0) o.err_early = 1;
                if (bus.s_req_o !== '0) begin
                    if ($countones(bus.s_req_o) != 1) o.sreq_bad = 1;
                    if (o.sreq_n == 0) begin
                        o.s_addr = bus.s_addr_o; o.s_wdata = bus.s_wdata_o;
                        o.s_we = bus.s_we_o; o.s_be = bus.s_be_o;
                    end
                    o.sreq_n++;
                    o.sreq_or |= bus.s_req_o;
                end
                sready = noise ? NS'($urandom) : '0;
                sready &= ~bus.s_req_o;
                if (bus.s_req_o !== '0 && o.sreq_n == b) sready |= bus.s_req_o;
                @(negedge clk);
            end
        end
        sready = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.be_i = 4'hF; bus.addr_i = 32'h0100_0000; bus.wdata_i = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.stall_o !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.stall_o); else passed++;
        total++; if (bus.rdata_o !== 32'd0) $display("FAIL reset_rdata got %h want 0", bus.rdata_o); else passed++;
        total++; if (bus.err_o !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err_o); else passed++;
        total++; if (bus.s_req_o !== '0) $display("FAIL reset_sreq got %h want 0", bus.s_req_o); else passed++;
        total++;
        if ({bus.s_we_o, bus.s_be_o, bus.s_addr_o, bus.s_wdata_o} !== '0)
            $display("FAIL reset_slave_side got %h want 0", {bus.s_we_o, bus.s_be_o, bus.s_addr_o, bus.s_wdata_o});
        else passed++;
        bus.req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_slave0();
        obs_t o;
        exp_t e;
        sdata[0] = 32'hCAFE_F00D;
        e = model(1'b0, 32'h0000_0010, 1);
        do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 1'b0, o);
        bus.req_i = 1'b0;
        total++; if (!o.done) $display("FAIL rd0_done got timeout want done"); else passed++;
        total++; if (o.stall_n != 2 || o.stall_n != e.stall_n) $display("FAIL rd0_stall got %0d want 2", o.stall_n); else passed++;
        total++; if (o.sreq_or !== 8'h01 || o.sreq_n != 1) $display("FAIL rd0_sreq got %h x%0d want 01 x1", o.sreq_or, o.sreq_n); else passed++;
        total++; if (o.s_addr !== 32'h0000_0010) $display("FAIL rd0_saddr got %h want 00000010", o.s_addr); else passed++;
        total++; if (o.rdata !== e.rdata || o.err !== 1'b0) $display("FAIL rd0_data got %h/%b want %h/0", o.rdata, o.err, e.rdata); else passed++;
    endtask

    task automatic test_write_uart();
        obs_t o;
        exp_t e;
        e = model(1'b1, 32'h0600_0000, 3);
        do_txn(1'b1, 32'h0600_0000, 32'h41, 4'b0001, 3, 1'b0, o);
        bus.req_i = 1'b0;
        total++; if (o.sreq_or !== 8'h40 || o.sreq_n != 3) $display("FAIL wr_sreq got %h x%0d want 40 x3", o.sreq_or, o.sreq_n); else passed++;
        total++; if (o.s_addr !== 32'h0 || o.s_we !== 1'b1) $display("FAIL wr_addr_we got %h/%b want 0/1", o.s_addr, o.s_we); else passed++;
        total++; if (o.s_wdata !== 32'h41 || o.s_be !== 4'b0001) $display("FAIL wr_data_be got %h/%b want 41/0001", o.s_wdata, o.s_be); else passed++;
        total++; if (o.stall_n != e.stall_n) $display("FAIL wr_stall got %0d want %0d", o.stall_n, e.stall_n); else passed++;
        total++; if (o.err !== 1'b0 || o.rdata !== 32'd0) $display("FAIL wr_done got %h/%b want 0/0", o.rdata, o.err); else passed++;
    endtask

    task automatic test_unmapped();
        obs_t o;
        do_txn(1'b0, 32'h0900_0000, 32'h0, 4'hF, 1, 1'b0, o);
        bus.req_i = 1'b0;
        total++; if (o.sreq_n != 0 || o.sreq_or !== '0) $display("FAIL unmap_sreq got %h x%0d want none", o.sreq_or, o.sreq_n); else passed++;
        total++; if (o.stall_n != 1) $display("FAIL unmap_stall got %0d want 1", o.stall_n); else passed++;
        total++; if (o.err !== 1'b1 || o.rdata !== 32'd0) $display("FAIL unmap_done got %h/%b want 0/1", o.rdata, o.err); else passed++;
        @(negedge clk);
        #1;
        total++; if (bus.err_o !== 1'b0) $display("FAIL unmap_err_clear got %b want 0", bus.err_o); else passed++;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        exp_t e1, e2;
        for (int k = 0; k < NS; k++) sdata[k] = $urandom;
        e1 = model(1'b0, 32'h0500_0020, 1);
        e2 = model(1'b0, 32'h0000_0040, 1);
        do_txn(1'b0, 32'h0500_0020, 32'h0, 4'hF, 1, 1'b1, o1);
        do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1, 1'b1, o2);
        bus.req_i = 1'b0;
        total++; if (o1.rdata !== e1.rdata || o1.sreq_or !== e1.sreq_or) $display("FAIL b2b_first got %h/%h want %h/%h", o1.rdata, o1.sreq_or, e1.rdata, e1.sreq_or); else passed++;
        total++; if (o2.rdata !== e2.rdata || o2.sreq_or !== e2.sreq_or) $display("FAIL b2b_second got %h/%h want %h/%h", o2.rdata, o2.sreq_or, e2.rdata, e2.sreq_or); else passed++;
        total++; if (o2.done_cyc - o1.done_cyc != 3) $display("FAIL b2b_spacing got %0d want 3", o2.done_cyc - o1.done_cyc); else passed++;
        total++; if (o2.rdata_first !== e1.rdata) $display("FAIL b2b_hold got %h want %h", o2.rdata_first, e1.rdata); else passed++;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        int   seen;
        bit   bad;
        sdata[1] = $urandom | 32'h1;
        do_txn(1'b0, 32'h0100_0000, 32'h0, 4'hF, 1, 1'b0, o);
        bus.req_i = 1'b0;
        seen = 0;
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0100_0004;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            #1;
            if (bus.s_req_o === 8'h02) seen++;
            if (seen < 2) @(negedge clk);
        end
        total++; if (seen != 2) $display("FAIL rstmid_busy got %0d busy cycles want 2", seen); else passed++;
        #1;
        rst = 1'b1;
        #1;
        total++; if (bus.s_req_o !== '0 || bus.stall_o !== 1'b0) $display("FAIL rstmid_async got %h/%b want 0/0", bus.s_req_o, bus.stall_o); else passed++;
        total++; if (bus.rdata_o !== 32'd0 || bus.err_o !== 1'b0) $display("FAIL rstmid_outs got %h/%b want 0/0", bus.rdata_o, bus.err_o); else passed++;
        @(negedge clk);
        rst = 1'b0;
        bus.req_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.err_o !== 1'b0 || bus.s_req_o !== '0 || bus.rdata_o !== 32'd0) bad = 1;
            @(negedge clk);
        end
        total++; if (bad) $display("FAIL rstmid_quiet got activity want none"); else passed++;
        e = model(1'b0, 32'h0100_0008, 1);
        do_txn(1'b0, 32'h0100_0008, 32'h0, 4'hF, 1, 1'b0, o);
        bus.req_i = 1'b0;
        total++; if (o.stall_n != e.stall_n || o.rdata !== e.rdata) $display("FAIL rstmid_after got %0d/%h want %0d/%h", o.stall_n, o.rdata, e.stall_n, e.rdata); else passed++;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        exp_t e;
        sdata[2] = $urandom;
        e = model(1'b0, 32'h0200_0000, 100);
        do_txn(1'b0, 32'h0200_0000, 32'h0, 4'hF, 100, 1'b0, o);
        bus.req_i = 1'b0;
        total++; if (o.sreq_n != 4 || o.sreq_or !== 8'h04) $display("FAIL to_sreq got %h x%0d want 04 x4", o.sreq_or, o.sreq_n); else passed++;
        total++; if (o.err !== 1'b1 || o.rdata !== e.rdata) $display("FAIL to_err got %h/%b want %h/1", o.rdata, o.err, e.rdata); else passed++;
        e = model(1'b0, 32'h0200_0000, 4);
        do_txn(1'b0, 32'h0200_0000, 32'h0, 4'hF, 4, 1'b0, o);
        bus.req_i = 1'b0;
        total++; if (o.err !== 1'b0 || o.rdata !== e.rdata) $display("FAIL to_race got %h/%b want %h/0", o.rdata, o.err, e.rdata); else passed++;
    endtask
`endif

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [31:0] prev;
        logic [31:0] addr;
        logic        we;
        int          b;
        int          sel;
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < NS; k++) sdata[k] = $urandom;
            sel  = $urandom_range(0, 9);
            addr = {8'(sel), 24'($urandom)};
            we   = 1'($urandom);
            b    = $urandom_range(1, 6);
            e    = model(we, addr, b);
            do_txn(we, addr, $urandom, 4'($urandom), b, 1'b1, o);
            if ($urandom_range(0, 1) == 1) bus.req_i = 1'b0;
            total++; if (!o.done) $display("FAIL rnd%0d_done got timeout want done", i); else passed++;
            total++; if (o.stall_n != e.stall_n || o.sreq_n != e.sreq_n) $display("FAIL rnd%0d_timing got %0d/%0d want %0d/%0d", i, o.stall_n, o.sreq_n, e.stall_n, e.sreq_n); else passed++;
            total++; if (o.sreq_or !== e.sreq_or || o.sreq_bad) $display("FAIL rnd%0d_sreq got %h bad=%0d want %h", i, o.sreq_or, o.sreq_bad, e.sreq_or); else passed++;
            total++; if (o.rdata !== e.rdata || o.err !== e.err || o.err_early) $display("FAIL rnd%0d_done got %h/%b early=%0d want %h/%b", i, o.rdata, o.err, o.err_early, e.rdata, e.err); else passed++;
            if (e.sreq_n > 0) begin
                total++; if (o.s_addr !== e.s_addr || o.s_we !== we) $display("FAIL rnd%0d_saddr got %h/%b want %h/%b", i, o.s_addr, o.s_we, e.s_addr, we); else passed++;
            end
            if (i > 0) begin
                total++; if (o.rdata_first !== prev) $display("FAIL rnd%0d_hold got %h want %h", i, o.rdata_first, prev); else passed++;
            end
            prev = e.rdata;
        end
        bus.req_i = 1'b0;
    endtask

    initial begin
        sready = '0;
        for (int k = 0; k < NS; k++) sdata[k] = '0;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
        test_reset();
        test_read_slave0();
        test_write_uart();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/periph_bus_ic.md
Name: periph_bus_ic

Overview:
- Parametrised system-bus interconnect between the core data port and up to N_SLAVES memory-mapped peripherals (RAM, UART RX/TX, switches/LEDs, PS/2, hex display).
- Decodes the slave from address field addr_i[SEL_MSB:SEL_LSB]; unmapped selectors return a bus error.
- Registers the read data and holds the core in stall until the selected slave signals ready.
- Replaces the fixed 3-way decode and unregistered read mux in the SoC top.

Parameters:
- N_SLAVES, 8, number of slave ports; selector values >= N_SLAVES are unmapped.
- SEL_MSB, 31, upper bit of the slave-select address field.
- SEL_LSB, 24, lower bit of the slave-select address field. SEL_MSB-SEL_LSB+1 <= 8.
- TIMEOUT_CYCLES, 255, BUSY cycles before abort (used only with BUS_TIMEOUT_EN).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  master request; master holds all request inputs stable while stall_o=1
- we_i  in  1  write enable
- be_i  in  4  byte enables
- addr_i  in  32  byte address
- wdata_i  in  32  write data
- rdata_o  out  32  registered read data, valid in the DONE cycle
- stall_o  out  1  master stall
- err_o  out  1  bus error, valid in the DONE cycle
- s_req_o  out  N_SLAVES  one-hot slave request
- s_we_o  out  1  latched we
- s_be_o  out  4  latched be
- s_addr_o  out  32  latched address with bits [SEL_MSB:SEL_LSB] forced to 0
- s_wdata_o  out  32  latched write data
- s_rdata_i  in  32*N_SLAVES  slave read data; slave k occupies bits [32k+31:32k]
- s_ready_i  in  N_SLAVES  per-slave completion; sampled only for the active slave

Behaviour:
- Reset (asynchronous, rst_i=1):
  - state=IDLE.
  - All outputs 0, including rdata_o, err_o and stall_o.
  - All latches and the timeout counter cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On req_i=1, latch we/be/addr/wdata and sel=addr_i[SEL_MSB:SEL_LSB].
  - sel < N_SLAVES: go to BUSY.
  - sel >= N_SLAVES: go to DONE with err flag=1 and rdata=0; no s_req_o is asserted.
- BUSY:
  - s_req_o[sel]=1; all other s_req_o bits 0.
  - s_we_o/s_be_o/s_addr_o/s_wdata_o driven from the latches.
  - On s_ready_i[sel]=1: rdata_o <= s_rdata_i[sel] (write: rdata_o <= 0), err flag=0, go to DONE.
  - s_ready_i bits of non-selected slaves are ignored.
- DONE:
  - Lasts exactly one cycle; rdata_o and err_o are valid.
  - Always returns to IDLE.
  - rdata_o holds its value until the next DONE; err_o is 1 only in DONE.
- stall_o = req_i & (state != DONE), combinational.
- Latency: a slave whose ready is tied high gives 2 stall cycles (IDLE accept, BUSY), with completion in cycle 3. An unmapped access gives 1 stall cycle.
- Back-to-back: req_i held high after DONE starts a new transaction in the following IDLE cycle. There is no pipelining.
- req_i dropped while in BUSY (protocol violation): the transaction still completes and passes through DONE. stall_o follows req_i.
- s_req_o is a pure state decode, never glitching to more than one bit.
- Reset asserted mid-transaction aborts immediately: s_req_o=0, no DONE pulse.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without ready, go to DONE with err_o=1 and rdata_o=0, and deassert s_req_o.
  - Ready arriving in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely for ready.

Test Plan:
- Read from slave 0 at addr 0x0000_0010, s_ready_i[0] tied 1, s_rdata_i[0]=0xCAFE_F00D -> s_req_o=0x01 for 1 cycle; s_addr_o=0x0000_0010; stall_o high 2 cycles; DONE shows rdata_o=0xCAFE_F00D, err_o=0.
- Write to 0x0600_0000 (UART TX) with wdata 0x41, be=0001, ready after 3 BUSY cycles -> s_req_o=0x40 for 3 cycles; s_addr_o=0x0000_0000, s_we_o=1, s_wdata_o=0x41; stall_o high 4 cycles; err_o=0.
- Read from 0x0900_0000 with N_SLAVES=8 -> no s_req_o bit set; 1 stall cycle; DONE shows err_o=1, rdata_o=0.
- Back-to-back reads from slave 5 then slave 0, both with ready=1 -> two DONE pulses 3 cycles apart; rdata_o updates in each DONE cycle; the unselected slave's s_ready_i pulse is ignored.
- rst_i asserted in the 2nd BUSY cycle -> s_req_o, stall_o, rdata_o and err_o go to 0 asynchronously; after release, state=IDLE.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave 2 never ready -> s_req_o[2] high 4 cycles, then DONE with err_o=1; repeat with ready arriving in the 4th cycle -> err_o=0 and rdata is captured.
